// File: rtl/uart_rx_cmd_buffer_if.sv
// ---------------------------------------------------------------------------
// uart_rx_cmd_buffer_if
// Sequencer-side view of the UART command buffer.
//   clear_buffer_i : sequencer -> receiver, one-cycle request to empty buffer
//   cmd_buffer_o   : receiver -> sequencer, last correctly framed byte
//   eor_o          : receiver -> sequencer, pulse when a new byte is loaded
//   buffer_full_o  : receiver -> sequencer, buffer holds an unconsumed byte
//   overrun_o      : receiver -> sequencer, pulse when an unconsumed byte
//                    was overwritten
//   frame_err_o    : receiver -> sequencer, pulse when a stop bit was low
// Modports: master = sequencer, slave = receiver.
// ---------------------------------------------------------------------------
interface uart_rx_cmd_buffer_if #(
   parameter int Width = 8
);
   logic             clear_buffer_i;
   logic [Width-1:0] cmd_buffer_o;
   logic             eor_o;
   logic             buffer_full_o;
   logic             overrun_o;
   logic             frame_err_o;

   modport master (
      output clear_buffer_i,
      input  cmd_buffer_o,
      input  eor_o,
      input  buffer_full_o,
      input  overrun_o,
      input  frame_err_o
   );

   modport slave (
      input  clear_buffer_i,
      output cmd_buffer_o,
      output eor_o,
      output buffer_full_o,
      output overrun_o,
      output frame_err_o
   );
endinterface

// File: rtl/uart_rx_cmd_buffer.sv
// ---------------------------------------------------------------------------
// uart_rx_cmd_buffer
// 8N1 UART receiver with a single-byte command buffer for a downstream
// command/measurement sequencer. Contains an oversampling tick generator,
// a 2-flop input synchronizer, the receive FSM and the buffer/flag logic.
// Ports:
//   clk_i  : system clock, rising edge
//   rst_i  : synchronous, active-high reset
//   rx_i   : asynchronous UART line, idle high
//   cmd_if : sequencer interface (slave side), see uart_rx_cmd_buffer_if
// Parameters:
//   Width   : data bits per frame (>= 1)
//   BaudDiv : clk_i cycles per oversampling tick (>= 2)
//   Ovs     : oversampling ticks per bit (even, >= 4)
// ---------------------------------------------------------------------------
module uart_rx_cmd_buffer #(
   parameter int Width   = 8,
   parameter int BaudDiv = 27,
   parameter int Ovs     = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 rx_i,
   uart_rx_cmd_buffer_if.slave  cmd_if
);
   localparam int CntW = $clog2(BaudDiv);
   localparam int SW   = $clog2(Ovs);
   localparam int NW   = $clog2(Width + 1);

   localparam logic [CntW-1:0] CNT_LAST = CntW'(BaudDiv - 1);
   localparam logic [SW-1:0]   S_HALF   = SW'(Ovs / 2 - 1);
   localparam logic [SW-1:0]   S_LAST   = SW'(Ovs - 1);
   localparam logic [NW-1:0]   N_LAST   = NW'(Width - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_t;

   // ------------------------------------------------------------------
   // Input synchronizer; both flops reset to the idle-high line level so
   // that reset never looks like a start edge.
   // ------------------------------------------------------------------
   logic rx_meta_reg;
   logic rx_s_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_meta_reg <= 1'b1;
         rx_s_reg    <= 1'b1;
      end else begin
         rx_meta_reg <= rx_i;
         rx_s_reg    <= rx_meta_reg;
      end
   end

   // ------------------------------------------------------------------
   // Free-running oversampling tick generator
   // ------------------------------------------------------------------
   logic [CntW-1:0] baud_cnt_reg;
   logic            tick;

   assign tick = (baud_cnt_reg == CNT_LAST);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         baud_cnt_reg <= '0;
      end else if (tick) begin
         baud_cnt_reg <= '0;
      end else begin
         baud_cnt_reg <= baud_cnt_reg + CntW'(1);
      end
   end

   // ------------------------------------------------------------------
   // Receive FSM
   // ------------------------------------------------------------------
   state_t           state_reg, state_next;
   logic [SW-1:0]    s_reg, s_next;
   logic [NW-1:0]    n_reg, n_next;
   logic [Width-1:0] shift_reg, shift_next;
   logic             commit_next;
   logic             ferr_next;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= ST_IDLE;
         s_reg     <= '0;
         n_reg     <= '0;
         shift_reg <= '0;
      end else begin
         state_reg <= state_next;
         s_reg     <= s_next;
         n_reg     <= n_next;
         shift_reg <= shift_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      s_next      = s_reg;
      n_next      = n_reg;
      shift_next  = shift_reg;
      commit_next = 1'b0;
      ferr_next   = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            s_next = '0;
            n_next = '0;
            // Start edge is taken on any clock, not only on a tick.
            if (!rx_s_reg) begin
               state_next = ST_START;
            end
         end

         ST_START: begin
            if (tick) begin
               if (s_reg == S_HALF) begin
                  // Mid start bit: still low means a real start,
                  // high means a glitch and we quietly give up.
                  s_next     = '0;
                  state_next = rx_s_reg ? ST_IDLE : ST_DATA;
               end else begin
                  s_next = s_reg + SW'(1);
               end
            end
         end

         ST_DATA: begin
            if (tick) begin
               if (s_reg == S_LAST) begin
                  // LSB arrives first, so shift in at the MSB end.
                  s_next                = '0;
                  shift_next            = shift_reg >> 1;
                  shift_next[Width-1]   = rx_s_reg;
                  n_next                = n_reg + NW'(1);
                  if (n_reg == N_LAST) begin
                     state_next = ST_STOP;
                  end
               end else begin
                  s_next = s_reg + SW'(1);
               end
            end
         end

         ST_STOP: begin
            if (tick) begin
               if (s_reg == S_LAST) begin
                  s_next     = '0;
                  state_next = ST_IDLE;
                  if (rx_s_reg) begin
                     commit_next = 1'b1;
                  end else begin
                     ferr_next = 1'b1;
                  end
               end else begin
                  s_next = s_reg + SW'(1);
               end
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Command buffer and status flags
   // ------------------------------------------------------------------
   logic [Width-1:0] cmd_buffer_reg;
   logic             eor_reg;
   logic             buffer_full_reg;
   logic             overrun_reg;
   logic             frame_err_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cmd_buffer_reg  <= '0;
         eor_reg         <= 1'b0;
         buffer_full_reg <= 1'b0;
         overrun_reg     <= 1'b0;
         frame_err_reg   <= 1'b0;
      end else begin
         eor_reg       <= commit_next;
         frame_err_reg <= ferr_next;
         // A clear arriving with the commit counts as consuming the old
         // byte, so it suppresses the overrun.
         overrun_reg   <= commit_next & buffer_full_reg & ~cmd_if.clear_buffer_i;
         if (commit_next) begin
            cmd_buffer_reg  <= shift_reg;
            buffer_full_reg <= 1'b1;
         end else if (cmd_if.clear_buffer_i) begin
            cmd_buffer_reg  <= '0;
            buffer_full_reg <= 1'b0;
         end
      end
   end

   assign cmd_if.cmd_buffer_o  = cmd_buffer_reg;
   assign cmd_if.eor_o         = eor_reg;
   assign cmd_if.buffer_full_o = buffer_full_reg;
   assign cmd_if.overrun_o     = overrun_reg;
   assign cmd_if.frame_err_o   = frame_err_reg;

endmodule

// File: tb/tb_uart_rx_cmd_buffer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_cmd_buffer
// Directed bench for uart_rx_cmd_buffer with BaudDiv=4, Ovs=16 (64 clk_i
// cycles per bit). Frames are driven LSB-first; a negedge monitor counts
// output pulses and expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_uart_rx_cmd_buffer;
   localparam int BIT = 64;

   logic clk_i = 1'b0;
   logic rst_i;
   logic rx_i;

   uart_rx_cmd_buffer_if #(.Width(8)) cmd_if ();

   uart_rx_cmd_buffer #(
      .Width   (8),
      .BaudDiv (4),
      .Ovs     (16)
   ) dut (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .rx_i   (rx_i),
      .cmd_if (cmd_if.slave)
   );

   always #5 clk_i = ~clk_i;

   // Cycle counter and pulse monitor
   int cyc = 0;
   int eor_cnt = 0;
   int ovr_cnt = 0;
   int ovr_eor_cnt = 0;
   int ferr_cnt = 0;
   int eor_cyc = 0;

   always @(posedge clk_i) cyc <= cyc + 1;

   always @(negedge clk_i) begin
      if (cmd_if.eor_o) begin
         eor_cnt = eor_cnt + 1;
         eor_cyc = cyc;
      end
      if (cmd_if.overrun_o) ovr_cnt = ovr_cnt + 1;
      if (cmd_if.overrun_o && cmd_if.eor_o) ovr_eor_cnt = ovr_eor_cnt + 1;
      if (cmd_if.frame_err_o) ferr_cnt = ferr_cnt + 1;
   end

   int chk_cnt = 0;
   int pass_cnt = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt = chk_cnt + 1;
      if (got === exp) begin
         pass_cnt = pass_cnt + 1;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive one frame: start, 8 data bits LSB first, stop bit held stop_len
   // cycles at level stop_bit, then idle high.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_len);
      rx_i = 1'b0;
      repeat (BIT) @(negedge clk_i);
      for (int i = 0; i < 8; i++) begin
         rx_i = b[i];
         repeat (BIT) @(negedge clk_i);
      end
      rx_i = stop_bit;
      repeat (stop_len) @(negedge clk_i);
      rx_i = 1'b1;
      repeat (2 * BIT) @(negedge clk_i);
      $display("frame sent: data=0x%02h stop=%0d", b, stop_bit);
   endtask

   task automatic align_phase();
      while (cyc % 4 != 0) @(negedge clk_i);
   endtask

   int e0, o0, oe0, f0;
   int start_cyc;
   int lat;

   task automatic snap();
      e0  = eor_cnt;
      o0  = ovr_cnt;
      oe0 = ovr_eor_cnt;
      f0  = ferr_cnt;
   endtask

   initial begin
      rst_i = 1'b1;
      rx_i  = 1'b1;
      cmd_if.clear_buffer_i = 1'b0;
      repeat (4) @(negedge clk_i);

      // Reset values
      check_eq("rst_cmd",   32'(cmd_if.cmd_buffer_o),  32'h0);
      check_eq("rst_flags", {28'h0, cmd_if.eor_o, cmd_if.buffer_full_o,
                             cmd_if.overrun_o, cmd_if.frame_err_o}, 32'h0);
      rst_i = 1'b0;
      repeat (8) @(negedge clk_i);

      // 1: single byte, also measure frame-start to eor latency
      snap();
      align_phase();
      start_cyc = cyc;
      send_frame(8'h01, 1'b1, BIT);
      lat = eor_cyc - start_cyc;
      check_eq("t1_eor_cnt", 32'(eor_cnt - e0), 32'd1);
      check_eq("t1_cmd",     32'(cmd_if.cmd_buffer_o), 32'h01);
      check_eq("t1_full",    32'(cmd_if.buffer_full_o), 32'd1);
      check_eq("t1_ovr",     32'(ovr_cnt - o0), 32'd0);
      check_eq("t1_ferr",    32'(ferr_cnt - f0), 32'd0);
      // Stop-bit centre is 9.5 bits after the start edge
      check_eq("t1_lat_win", 32'((lat >= 608) && (lat <= 672)), 32'd1);

      // 3: bad stop bit; stop held low long enough to cover its centre
      snap();
      send_frame(8'h55, 1'b0, 48);
      check_eq("t3_ferr",    32'(ferr_cnt - f0), 32'd1);
      check_eq("t3_eor",     32'(eor_cnt - e0), 32'd0);
      check_eq("t3_cmd",     32'(cmd_if.cmd_buffer_o), 32'h01);
      check_eq("t3_full",    32'(cmd_if.buffer_full_o), 32'd1);

      // Empty the buffer before the overrun scenario
      cmd_if.clear_buffer_i = 1'b1;
      @(negedge clk_i);
      cmd_if.clear_buffer_i = 1'b0;
      $display("clear pulse");
      check_eq("clr0_full",  32'(cmd_if.buffer_full_o), 32'd0);

      // 2: two bytes without consuming -> overrun on the second
      snap();
      send_frame(8'hA5, 1'b1, BIT);
      check_eq("t2_a5_ovr",  32'(ovr_cnt - o0), 32'd0);
      send_frame(8'h3C, 1'b1, BIT);
      check_eq("t2_eor_cnt", 32'(eor_cnt - e0), 32'd2);
      check_eq("t2_ovr_eor", 32'(ovr_eor_cnt - oe0), 32'd1);
      check_eq("t2_ovr_cnt", 32'(ovr_cnt - o0), 32'd1);
      check_eq("t2_cmd",     32'(cmd_if.cmd_buffer_o), 32'h3C);
      cmd_if.clear_buffer_i = 1'b1;
      @(negedge clk_i);
      cmd_if.clear_buffer_i = 1'b0;
      $display("clear pulse");
      check_eq("t2_clr_cmd", 32'(cmd_if.cmd_buffer_o), 32'h00);
      check_eq("t2_clr_full", 32'(cmd_if.buffer_full_o), 32'd0);

      // 4: short glitch then a good byte
      snap();
      rx_i = 1'b0;
      repeat (20) @(negedge clk_i);
      rx_i = 1'b1;
      repeat (2 * BIT) @(negedge clk_i);
      $display("glitch sent: 20 cycles low");
      check_eq("t4_gl_eor",  32'(eor_cnt - e0), 32'd0);
      check_eq("t4_gl_ferr", 32'(ferr_cnt - f0), 32'd0);
      send_frame(8'h7E, 1'b1, BIT);
      check_eq("t4_eor",     32'(eor_cnt - e0), 32'd1);
      check_eq("t4_cmd",     32'(cmd_if.cmd_buffer_o), 32'h7E);
      check_eq("t4_ferr",    32'(ferr_cnt - f0), 32'd0);

      // 5: clear in the exact commit cycle while full; same tick phase as
      // test 1, so the commit edge is start + lat.
      snap();
      align_phase();
      start_cyc = cyc;
      fork
         send_frame(8'h81, 1'b1, BIT);
         begin
            while (cyc < start_cyc + lat - 1) @(negedge clk_i);
            cmd_if.clear_buffer_i = 1'b1;
            @(negedge clk_i);
            cmd_if.clear_buffer_i = 1'b0;
            $display("clear pulse at cycle %0d", cyc - 1);
         end
      join
      check_eq("t5_eor",     32'(eor_cnt - e0), 32'd1);
      check_eq("t5_eor_cyc", 32'(eor_cyc - start_cyc), 32'(lat));
      check_eq("t5_cmd",     32'(cmd_if.cmd_buffer_o), 32'h81);
      check_eq("t5_full",    32'(cmd_if.buffer_full_o), 32'd1);
      check_eq("t5_ovr",     32'(ovr_cnt - o0), 32'd0);

      // 6: reset in the middle of the data bits of 0xFF
      snap();
      fork
         send_frame(8'hFF, 1'b1, BIT);
         begin
            repeat (200) @(negedge clk_i);
            rst_i = 1'b1;
            repeat (3) @(negedge clk_i);
            rst_i = 1'b0;
            $display("reset pulse mid-frame");
         end
      join
      check_eq("t6_ab_eor",  32'(eor_cnt - e0), 32'd0);
      check_eq("t6_ab_ferr", 32'(ferr_cnt - f0), 32'd0);
      check_eq("t6_ab_ovr",  32'(ovr_cnt - o0), 32'd0);
      check_eq("t6_ab_cmd",  32'(cmd_if.cmd_buffer_o), 32'h00);
      check_eq("t6_ab_full", 32'(cmd_if.buffer_full_o), 32'd0);
      send_frame(8'h02, 1'b1, BIT);
      check_eq("t6_eor",     32'(eor_cnt - e0), 32'd1);
      check_eq("t6_cmd",     32'(cmd_if.cmd_buffer_o), 32'h02);
      check_eq("t6_full",    32'(cmd_if.buffer_full_o), 32'd1);
      check_eq("t6_ferr",    32'(ferr_cnt - f0), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
